// File: rtl/rv32i_encoder_if.sv
// Handshake bus for the RV32I encoder: tuple input side and encoded-word output side.
interface rv32i_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  // Producer of tuples / consumer of words (program generator side).
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/rv32i_encoder.sv
// RV32I encoder: packs format/field tuples into 32-bit instruction words,
// with a one-entry skid buffer, a registered output stage, immediate range
// checking (illegal tuples become NOPs) and a load-address counter.
module rv32i_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  rv32i_encoder_if.slave       bus,
  output logic [7:0]           err_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic               accept;
  logic               out_free;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_addr_q,  skid_addr_d;
  logic              skid_err_q,   skid_err_d;
  logic [ADDR_W-1:0] addr_cnt_q,   addr_cnt_d;
  logic [7:0]        err_count_q,  err_count_d;

  assign imm_s = bus.in_imm;

  // Encode the incoming tuple and decide whether it is legal.
  always_comb begin
    enc_err   = 1'b0;
    enc_instr = NOP;
    case (bus.in_fmt)
      FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      FMT_I: begin
        enc_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        enc_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_imm[4:0], bus.in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        enc_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                     bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      end
      FMT_U: begin
        enc_instr = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err   = (bus.in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                     bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
    if (bus.in_opcode[1:0] != 2'b11) enc_err = 1'b1;
    if (enc_err) enc_instr = NOP;
  end

  // Next-state for output stage, skid buffer, address counter and error counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_err_d   = skid_err_q;
    addr_cnt_d   = addr_cnt_q;
    err_count_d  = err_count_q;

    accept   = bus.in_valid && !skid_valid_q;
    out_free = !out_valid_q || bus.out_ready;

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_addr_d   = skid_addr_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_instr;
        out_addr_d  = addr_cnt_q;
        out_err_d   = enc_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = enc_instr;
      skid_addr_d  = addr_cnt_q;
      skid_err_d   = enc_err;
    end

    if (accept) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(4);
      if (enc_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end
    if (restart) addr_cnt_d = BASE_ADDR;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_ADDR;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= BASE_ADDR;
      skid_err_q   <= 1'b0;
      addr_cnt_q   <= BASE_ADDR;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_err_q   <= skid_err_d;
      addr_cnt_q   <= addr_cnt_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign err_count     = err_count_q;

endmodule
